// File: rtl/lm71_temp_reader.sv
// Read-only serial reader for the LM71 temperature sensor (3-wire SPI-like).
// Polls periodically or on demand and presents raw and integer-degree readings.
module lm71_temp_reader #(
    parameter int unsigned CLK_DIV     = 25,
    parameter int unsigned POLL_CYCLES = 15_000_000
) (
    input  logic        clk_50,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        start,
    input  logic        temp_sio_in,
    output logic        temp_cs_n,
    output logic        temp_sc,
    output logic [13:0] temp_raw,
    output logic [8:0]  temp_c,
    output logic        temp_valid,
    output logic        temp_err,
    output logic        busy
);

    localparam int unsigned DIV_W  = $clog2(2 * CLK_DIV);
    localparam int unsigned POLL_W = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;
    localparam logic [2:0] ST_GAP   = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [3:0]        bit_q, bit_d;
    logic              phase_q, phase_d;
    logic [15:0]       shift_q, shift_d;
    logic [POLL_W-1:0] poll_q, poll_d;
    logic [1:0]        sync_q;
    logic              cs_n_q, cs_n_d;
    logic              sc_q, sc_d;
    logic [13:0]       raw_q, raw_d;
    logic [8:0]        c_q, c_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              poll_hit_c;
    logic              trigger_c;
    logic              div_end_c;

    always_ff @(posedge clk_50) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            phase_q <= 1'b0;
            shift_q <= '0;
            poll_q  <= '0;
            sync_q  <= '0;
            cs_n_q  <= 1'b1;
            sc_q    <= 1'b0;
            raw_q   <= '0;
            c_q     <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            phase_q <= phase_d;
            shift_q <= shift_d;
            poll_q  <= poll_d;
            sync_q  <= {sync_q[0], temp_sio_in};
            cs_n_q  <= cs_n_d;
            sc_q    <= sc_d;
            raw_q   <= raw_d;
            c_q     <= c_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_d      = bit_q;
        phase_d    = phase_q;
        shift_d    = shift_q;
        poll_d     = poll_q;
        raw_d      = raw_q;
        c_d        = c_q;
        err_d      = err_q;
        trigger_c  = 1'b0;
        poll_hit_c = enable && (poll_q == POLL_W'(POLL_CYCLES - 1));
        div_end_c  = (div_q == DIV_W'(CLK_DIV - 1));

        case (state_q)
            ST_IDLE: begin
                if (start || poll_hit_c) begin
                    trigger_c = 1'b1;
                    state_d   = ST_SETUP;
                    div_d     = '0;
                end
            end
            ST_SETUP: begin
                if (div_end_c) begin
                    state_d = ST_SHIFT;
                    div_d   = '0;
                    bit_d   = '0;
                    phase_d = 1'b0;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_SHIFT: begin
                if (div_end_c) begin
                    div_d = '0;
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else begin
                        // Sample at the end of the sc-high phase, MSB first
                        shift_d = {shift_q[14:0], sync_q[1]};
                        phase_d = 1'b0;
                        if (bit_q == 4'd15) begin
                            state_d = ST_HOLD;
                        end else begin
                            bit_d = bit_q + 4'd1;
                        end
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_HOLD: begin
                if (div_end_c) begin
                    state_d = ST_DONE;
                    div_d   = '0;
                    if (shift_q[1:0] == 2'b11) begin
                        raw_d = shift_q[15:2];
                        c_d   = shift_q[15:7];
                        err_d = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_GAP;
                div_d   = '0;
            end
            ST_GAP: begin
                if (div_q == DIV_W'(2 * CLK_DIV - 2)) begin
                    state_d = ST_IDLE;
                    div_d   = '0;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                div_d   = '0;
            end
        endcase

        // Poll counter restarts on every accepted frame and whenever polling is off
        if (!enable || trigger_c || poll_hit_c) begin
            poll_d = '0;
        end else begin
            poll_d = poll_q + POLL_W'(1);
        end

        cs_n_d  = !((state_d == ST_SETUP) || (state_d == ST_SHIFT) || (state_d == ST_HOLD));
        sc_d    = (state_d == ST_SHIFT) && phase_d;
        valid_d = (state_d == ST_DONE);
        busy_d  = (state_d != ST_IDLE);
    end

    assign temp_cs_n  = cs_n_q;
    assign temp_sc    = sc_q;
    assign temp_raw   = raw_q;
    assign temp_c     = c_q;
    assign temp_valid = valid_q;
    assign temp_err   = err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_lm71_temp_reader.sv
// Directed self-checking bench for lm71_temp_reader with a behavioural LM71 model.
module tb_lm71_temp_reader;

    logic        clk_50 = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        start;
    logic        sio_model;
    logic        temp_cs_n;
    logic        temp_sc;
    logic [13:0] temp_raw;
    logic [8:0]  temp_c;
    logic        temp_valid;
    logic        temp_err;
    logic        busy;

    int tests = 0;
    int fails = 0;

    lm71_temp_reader #(
        .CLK_DIV     (4),
        .POLL_CYCLES (200)
    ) dut (
        .clk_50      (clk_50),
        .reset_n     (reset_n),
        .enable      (enable),
        .start       (start),
        .temp_sio_in (sio_model),
        .temp_cs_n   (temp_cs_n),
        .temp_sc     (temp_sc),
        .temp_raw    (temp_raw),
        .temp_c      (temp_c),
        .temp_valid  (temp_valid),
        .temp_err    (temp_err),
        .busy        (busy)
    );

    always #5 clk_50 = ~clk_50;

    // Sensor model: MSB driven when cs_n falls, next bit after each sc falling edge
    logic [15:0] model_word = 16'h0000;
    int          bit_idx    = 15;
    logic        in_frame   = 1'b0;
    initial sio_model = 1'b0;

    always @(temp_cs_n or negedge temp_sc) begin
        if (temp_cs_n !== 1'b0) begin
            in_frame = 1'b0;
        end else if (!in_frame) begin
            in_frame  = 1'b1;
            bit_idx   = 15;
            sio_model = model_word[15];
        end else if (bit_idx > 0) begin
            bit_idx   = bit_idx - 1;
            sio_model = model_word[bit_idx];
        end
    end

    // Bus monitor, sampled just after each rising edge
    int   cyc           = 0;
    int   cs_low_total  = 0;
    int   sc_rise_total = 0;
    int   valid_total   = 0;
    int   fall_q[$];
    logic sc_prev       = 1'b0;
    logic cs_prev       = 1'b1;

    always @(posedge clk_50) begin
        #1;
        cyc = cyc + 1;
        if (temp_cs_n === 1'b0) cs_low_total = cs_low_total + 1;
        if (temp_cs_n === 1'b0 && temp_sc === 1'b1 && sc_prev === 1'b0) sc_rise_total = sc_rise_total + 1;
        if (temp_cs_n === 1'b0 && cs_prev === 1'b1) fall_q.push_back(cyc);
        if (temp_valid === 1'b1) valid_total = valid_total + 1;
        sc_prev = temp_sc;
        cs_prev = temp_cs_n;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests = tests + 1;
        assert (obs === exp) else begin
            fails = fails + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_start(input string tag, input logic [15:0] w, input logic [13:0] er,
                             input logic [8:0] ec, input logic ee);
        int cl0;
        int sr0;
        int v0;
        int n;
        logic got;
        model_word = w;
        cl0 = cs_low_total;
        sr0 = sc_rise_total;
        v0  = valid_total;
        start = 1'b1;
        @(negedge clk_50);
        start = 1'b0;
        chk({tag, "_cs_fall"}, 32'(temp_cs_n), 32'd0);
        chk({tag, "_busy_rise"}, 32'(busy), 32'd1);
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk_50);
            got = temp_valid;
        end
        chk({tag, "_valid_seen"}, 32'(got), 32'd1);
        chk({tag, "_cs_at_valid"}, 32'(temp_cs_n), 32'd1);
        chk({tag, "_cs_low_len"}, cs_low_total - cl0, 32'd136);
        chk({tag, "_sc_rises"}, sc_rise_total - sr0, 32'd16);
        chk({tag, "_raw"}, 32'(temp_raw), 32'(er));
        chk({tag, "_c"}, 32'(temp_c), 32'(ec));
        chk({tag, "_err"}, 32'(temp_err), 32'(ee));
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_50);
            if (!busy) break;
            n = n + 1;
        end
        chk({tag, "_gap_busy"}, n, 32'd7);
        chk({tag, "_valid_once"}, valid_total - v0, 32'd1);
    endtask

    int c0;
    int nf0;
    int v0;
    int sr0;
    int obs_t;

    initial begin
        reset_n = 1'b0;
        enable  = 1'b0;
        start   = 1'b0;
        repeat (3) @(negedge clk_50);
        chk("rst_cs_n", 32'(temp_cs_n), 32'd1);
        chk("rst_sc", 32'(temp_sc), 32'd0);
        chk("rst_raw", 32'(temp_raw), 32'd0);
        chk("rst_c", 32'(temp_c), 32'd0);
        chk("rst_valid", 32'(temp_valid), 32'd0);
        chk("rst_err", 32'(temp_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk_50);

        run_start("w0C83", 16'h0C83, 14'h0320, 9'd25, 1'b0);
        run_start("wEC03", 16'hEC03, 14'h3B00, 9'h1D8, 1'b0);
        run_start("w4B03", 16'h4B03, 14'h12C0, 9'd150, 1'b0);
        run_start("wFFFF", 16'hFFFF, 14'h3FFF, 9'h1FF, 1'b0);
        run_start("w0C83b", 16'h0C83, 14'h0320, 9'd25, 1'b0);
        run_start("w0C80", 16'h0C80, 14'h0320, 9'd25, 1'b1);

        // Periodic polling with start pulses dropped while busy
        model_word = 16'h0C83;
        c0  = cyc;
        nf0 = fall_q.size();
        enable = 1'b1;
        for (int i = 1; i <= 990; i++) begin
            start = (i == 250 || i == 450);
            @(negedge clk_50);
        end
        enable = 1'b0;
        start  = 1'b0;
        repeat (200) @(negedge clk_50);
        chk("poll_frames", fall_q.size() - nf0, 32'd4);
        for (int j = 0; j < 4; j++) begin
            obs_t = (nf0 + j < fall_q.size()) ? fall_q[nf0 + j] - c0 : -1;
            chk($sformatf("poll_fall%0d", j), obs_t, 32'(200 * (j + 1)));
        end
        chk("poll_err", 32'(temp_err), 32'd0);

        // start coinciding with poll expiry, then enable dropped mid-count
        c0  = cyc;
        nf0 = fall_q.size();
        v0  = valid_total;
        enable = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            start = (i == 200);
            @(negedge clk_50);
        end
        enable = 1'b0;
        start  = 1'b0;
        repeat (300) @(negedge clk_50);
        chk("coinc_frames", fall_q.size() - nf0, 32'd1);
        obs_t = (nf0 < fall_q.size()) ? fall_q[nf0] - c0 : -1;
        chk("coinc_fall_time", obs_t, 32'd200);
        chk("coinc_valid", valid_total - v0, 32'd1);

        // Re-enable briefly: a held counter would fire within 150 cycles
        nf0 = fall_q.size();
        enable = 1'b1;
        repeat (150) @(negedge clk_50);
        enable = 1'b0;
        repeat (10) @(negedge clk_50);
        chk("disable_clears", fall_q.size() - nf0, 32'd0);

        // Reset during bit 7 of the shift phase
        model_word = 16'h0C83;
        sr0 = sc_rise_total;
        v0  = valid_total;
        start = 1'b1;
        @(negedge clk_50);
        start = 1'b0;
        for (int i = 0; i < 200 && (sc_rise_total - sr0) < 8; i++) @(negedge clk_50);
        chk("mid_reached_bit7", sc_rise_total - sr0, 32'd8);
        reset_n = 1'b0;
        @(negedge clk_50);
        chk("mid_cs_n", 32'(temp_cs_n), 32'd1);
        chk("mid_sc", 32'(temp_sc), 32'd0);
        chk("mid_raw", 32'(temp_raw), 32'd0);
        chk("mid_c", 32'(temp_c), 32'd0);
        chk("mid_err", 32'(temp_err), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        @(negedge clk_50);
        reset_n = 1'b1;
        repeat (20) @(negedge clk_50);
        chk("mid_no_valid", valid_total - v0, 32'd0);
        run_start("post_rst", 16'h0C83, 14'h0320, 9'd25, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
